ysyx_22041071_mem_arbiter: RTL
==============================

// Module: ysyx_22041071_mem_arbiter
// PURPOSE
//  Shares the single RAMHelper-style memory port between the fetch stage (I side)
//  and the MEM stage load/store path (D side). Both sides use valid/ready
//  handshakes. Data has priority over fetch, with a streak limit that prevents
//  fetch starvation. One transaction is outstanding at a time; the response is
//  held until the requester accepts it.
// PARAMETERS
//  BASE          64'h8000_0000  physical base; idx = (addr - BASE) >> 3
//  MAX_D_STREAK  4              consecutive D grants allowed while I is waiting (>=1)
// PORTS
//  clk          in   1   clock
//  reset        in   1   asynchronous, active-high reset
//  i_req_valid  in   1   fetch request valid
//  i_req_ready  out  1   fetch request accepted this cycle
//  i_req_addr   in   64  fetch address (4-byte aligned)
//  i_rsp_valid  out  1   fetch response valid
//  i_rsp_ready  in   1   fetch response accepted
//  i_rsp_data   out  32  instruction word
//  d_req_valid  in   1   data request valid
//  d_req_ready  out  1   data request accepted this cycle
//  d_req_addr   in   64  data address
//  d_req_wen    in   1   1 = store, 0 = load
//  d_req_wdata  in   64  store data, already lane-aligned by requester
//  d_req_wmask  in   8   byte enables, bit k -> byte k
//  d_rsp_valid  out  1   data response valid (load data or store ack)
//  d_rsp_ready  in   1   data response accepted
//  d_rsp_rdata  out  64  raw 64-bit load word (0 for stores)
//  mem_en       out  1   read enable to memory
//  mem_ridx     out  64  read index
//  mem_rdata    in   64  read data, valid the cycle after mem_en
//  mem_widx     out  64  write index
//  mem_wdata    out  64  write data
//  mem_wmask    out  64  bit mask; each wmask bit expanded x8
//  mem_wen      out  1   write enable
// BEHAVIOUR
//  - States: IDLE, I_DATA, I_RSP, D_DATA, D_RSP. Registers: state, owner, streak,
//    rsp_q[63:0], isel (i_req_addr[2]).
//  - Reset (async): state=IDLE, streak=0, rsp_q=0. While reset=1 every output is 0.
//  - Requests are accepted only in IDLE. The grant is combinational in IDLE:
//    D wins if d_req_valid && !(i_req_valid && streak==MAX_D_STREAK); else I
//    wins if i_req_valid. Exactly one ready is high, and only on a grant.
//  - Grant cycle drives memory combinationally:
//    mem_ridx = mem_widx = (addr - BASE) >> 3;
//    mem_en = 1 for reads; mem_wen = 1 for stores (mem_en = 0 on stores).
//    mem_wdata and mem_wmask come from d_req_*. All mem_* outputs are 0 outside
//    grant cycles.
//  - I grant -> I_DATA (rsp_q <= mem_rdata) -> I_RSP.
//    i_rsp_data = isel ? rsp_q[63:32] : rsp_q[31:0].
//  - D load -> D_DATA (rsp_q <= mem_rdata) -> D_RSP.
//    D store -> D_RSP directly with rsp_q <= 0.
//  - *_RSP: rsp_valid=1 and data stable until rsp_ready, then IDLE.
//    Latency from accept cycle N: reads N+2, store ack N+1.
//    Minimum spacing between grants: 3 cycles for reads, 2 cycles for stores.
//  - streak: on a D grant, streak+1 (saturating) if i_req_valid, else cleared to 0.
//    Cleared to 0 on an I grant.
//  - Addresses below BASE wrap modulo 2^64; no checking is done.
//  - Requesters must hold request fields stable while valid && !ready.
//  - Reset mid-transaction: the transaction is dropped and no response is issued.
//    A store that was already issued stays committed.
// TESTING
//  1 Fetch 0x8000_0004, mem[0]=64'h1122334455667788 -> mem_ridx=0, mem_en for 1 cycle;
//    i_rsp_valid at N+2 with i_rsp_data=32'h11223344.
//  2 I and D read both valid in the same cycle -> d_req_ready=1, i_req_ready=0;
//    I is granted in the first IDLE cycle after d_rsp handshake.
//  3 D and I held valid continuously, MAX_D_STREAK=4 -> grants D,D,D,D,I, streak resets to 0.
//  4 Store addr 0x8000_0010, wmask 8'h0F, wdata 64'hCAFE -> mem_widx=2,
//    mem_wmask=64'h0000_0000_FFFF_FFFF, mem_wen for 1 cycle; d_rsp_valid at N+1, rdata=0.
//  5 Hold d_rsp_ready=0 for 5 cycles in D_RSP -> d_rsp_valid/rdata stable, no new grant,
//    mem_en=0 throughout.
//  6 Assert reset during D_DATA -> all outputs 0 immediately; after release, no stale
//    d_rsp_valid and state is IDLE.

Source files
------------

// File: rtl/ysyx_22041071_mem_arbiter.sv
// Shares one RAMHelper-style memory port between instruction fetch and data load/store.
// Data requests have priority, but a bounded streak stops them from starving fetch.
module ysyx_22041071_mem_arbiter #(
  parameter logic [63:0] BASE         = 64'h8000_0000,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [63:0] i_req_addr,
  output logic        i_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] i_rsp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [63:0] d_req_addr,
  input  logic        d_req_wen,
  input  logic [63:0] d_req_wdata,
  input  logic [7:0]  d_req_wmask,
  output logic        d_rsp_valid,
  input  logic        d_rsp_ready,
  output logic [63:0] d_rsp_rdata,
  output logic        mem_en,
  output logic [63:0] mem_ridx,
  input  logic [63:0] mem_rdata,
  output logic [63:0] mem_widx,
  output logic [63:0] mem_wdata,
  output logic [63:0] mem_wmask,
  output logic        mem_wen
);

  // IDLE: arbitrate | I_DATA/D_DATA: capture mem_rdata | I_RSP/D_RSP: hold response until accepted
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_I_DATA = 3'd1,
    S_I_RSP  = 3'd2,
    S_D_DATA = 3'd3,
    S_D_RSP  = 3'd4
  } state_t;

  localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_streak;
  logic [63:0]   r_rsp_q;
  logic          r_isel;

  logic          w_idle;
  logic          w_streak_full;
  logic          w_grant_d;
  logic          w_grant_i;
  logic [63:0]   w_i_idx;
  logic [63:0]   w_d_idx;
  logic [63:0]   w_wmask_bits;

  assign w_idle        = (r_state == S_IDLE) && !reset;
  assign w_streak_full = (r_streak == STREAK_MAX);
  assign w_grant_d     = w_idle && d_req_valid && !(i_req_valid && w_streak_full);
  assign w_grant_i     = w_idle && i_req_valid && !w_grant_d;

  // Addresses below BASE simply wrap; the memory model owns range checking.
  assign w_i_idx = (i_req_addr - BASE) >> 3;
  assign w_d_idx = (d_req_addr - BASE) >> 3;

  always_comb begin
    w_wmask_bits = '0;
    for (int k = 0; k < 8; k++) begin
      w_wmask_bits[8*k +: 8] = {8{d_req_wmask[k]}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = d_req_wen ? S_D_RSP : S_D_DATA;
        end else if (w_grant_i) begin
          w_state_nxt = S_I_DATA;
        end
      end
      S_I_DATA: w_state_nxt = S_I_RSP;
      S_I_RSP: begin
        if (i_rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_D_DATA: w_state_nxt = S_D_RSP;
      S_D_RSP: begin
        if (d_rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Streak counts only data grants made while a fetch was left waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_streak <= '0;
      r_rsp_q  <= '0;
      r_isel   <= 1'b0;
    end else begin
      if (w_grant_d) begin
        if (!i_req_valid) begin
          r_streak <= '0;
        end else if (!w_streak_full) begin
          r_streak <= r_streak + SW'(1);
        end
        if (d_req_wen) begin
          r_rsp_q <= '0;
        end
      end else if (w_grant_i) begin
        r_streak <= '0;
        r_isel   <= i_req_addr[2];
      end
      if (r_state == S_I_DATA || r_state == S_D_DATA) begin
        r_rsp_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    i_req_ready = w_grant_i;
    d_req_ready = w_grant_d;
    i_rsp_valid = 1'b0;
    i_rsp_data  = '0;
    d_rsp_valid = 1'b0;
    d_rsp_rdata = '0;
    mem_en      = 1'b0;
    mem_wen     = 1'b0;
    mem_ridx    = '0;
    mem_widx    = '0;
    mem_wdata   = '0;
    mem_wmask   = '0;
    if (!reset && r_state == S_I_RSP) begin
      i_rsp_valid = 1'b1;
      i_rsp_data  = r_isel ? r_rsp_q[63:32] : r_rsp_q[31:0];
    end
    if (!reset && r_state == S_D_RSP) begin
      d_rsp_valid = 1'b1;
      d_rsp_rdata = r_rsp_q;
    end
    if (w_grant_d) begin
      mem_en    = !d_req_wen;
      mem_wen   = d_req_wen;
      mem_ridx  = w_d_idx;
      mem_widx  = w_d_idx;
      mem_wdata = d_req_wdata;
      mem_wmask = w_wmask_bits;
    end else if (w_grant_i) begin
      mem_en   = 1'b1;
      mem_ridx = w_i_idx;
      mem_widx = w_i_idx;
    end
  end

  a_one_grant: assert property (@(posedge clk) disable iff (reset)
    !(i_req_ready && d_req_ready));
  a_en_wen_excl: assert property (@(posedge clk) disable iff (reset)
    !(mem_en && mem_wen));

endmodule
